// File: rtl/led_chaser_if.sv
// Step inputs from the blink stage toward the LED chaser, and the registered LED drive back.
// master drives blink_in/enable/mode; slave (the chaser) drives leds/wrap.
interface led_chaser_if #(
   parameter int WIDTH = 8
);
   logic             blink_in;
   logic             enable;
   logic [1:0]       mode;
   logic [WIDTH-1:0] leds;
   logic             wrap;

   modport master (output blink_in, enable, mode, input leds, wrap);
   modport slave  (input blink_in, enable, mode, output leds, wrap);
endinterface

// File: rtl/led_chaser.sv
// One-hot LED chaser stepped by blink_in rises (hold/rotl/rotr/bounce); optional PWM dimming via LED_DIM_EN.
// pattern updates on the detecting edge, leds/wrap one cycle later; no backpressure, steps are never stalled.
module led_chaser #(
   parameter int WIDTH     = 8,
   parameter int DUTY_BITS = 4,
   parameter int DUTY      = 8
) (
   input logic          clk,
   input logic          rst,
   led_chaser_if.slave  bus
);
   typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} dir_t;

   if (WIDTH < 2 || DUTY_BITS < 1 || DUTY_BITS > 31 || DUTY < 0) begin : g_param_check
      $error("led_chaser: illegal parameter combination");
   end

   logic             blink_d;
   logic [WIDTH-1:0] pattern;
   logic [WIDTH-1:0] pattern_nxt;
   dir_t             dir;
   dir_t             dir_nxt;
   logic             wrap_nxt;
   logic             wrap_pend;
   logic [WIDTH-1:0] leds_q;
   logic             wrap_q;
   logic             lit;
   logic             step;
   logic             take;
   logic [WIDTH-1:0] rotl;
   logic [WIDTH-1:0] rotr;

   assign step = bus.blink_in & ~blink_d;
   assign take = step & bus.enable & (bus.mode != 2'b00);
   assign rotl = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
   assign rotr = {pattern[0], pattern[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir <= LEFT;
      end else begin
         dir <= dir_nxt;
      end
   end

   // Rotating is also correct for bounce: away from the ends it equals a plain shift.
   always_comb begin
      pattern_nxt = pattern;
      dir_nxt     = dir;
      wrap_nxt    = 1'b0;
      if (take) begin
         unique case (bus.mode)
            2'b01: begin
               pattern_nxt = rotl;
               dir_nxt     = LEFT;
               wrap_nxt    = pattern[WIDTH-1];
            end
            2'b10: begin
               pattern_nxt = rotr;
               dir_nxt     = RIGHT;
               wrap_nxt    = pattern[0];
            end
            2'b11: begin
               if (dir == LEFT && pattern[WIDTH-1]) begin
                  dir_nxt     = RIGHT;
                  pattern_nxt = rotr;
                  wrap_nxt    = 1'b1;
               end else if (dir == RIGHT && pattern[0]) begin
                  dir_nxt     = LEFT;
                  pattern_nxt = rotl;
                  wrap_nxt    = 1'b1;
               end else if (dir == LEFT) begin
                  pattern_nxt = rotl;
               end else begin
                  pattern_nxt = rotr;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LED_DIM_EN
   logic [DUTY_BITS-1:0] pwm_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   // DUTY at or above the period length leaves the comparison always true.
   assign lit = 32'(pwm_cnt) < 32'(DUTY);
`else
   assign lit = 1'b1;
`endif

   // wrap_pend delays the wrap flag so it lines up with the leds update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_d   <= 1'b0;
         pattern   <= WIDTH'(1);
         wrap_pend <= 1'b0;
         leds_q    <= '0;
         wrap_q    <= 1'b0;
      end else begin
         blink_d   <= bus.blink_in;
         pattern   <= pattern_nxt;
         wrap_pend <= wrap_nxt;
         leds_q    <= lit ? pattern : '0;
         wrap_q    <= wrap_pend;
      end
   end

   assign bus.leds = leds_q;
   assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser: reset, rotate, bounce, gating, back-to-back steps, async reset.
module tb_led_chaser;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   led_chaser_if #(.WIDTH(8)) bus ();

   led_chaser #(.WIDTH(8), .DUTY_BITS(4), .DUTY(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-cycle blink pulse; returns at the negedge where blink_in drops.
   task automatic pulse();
      @(negedge clk);
      bus.blink_in = 1'b1;
      @(negedge clk);
      bus.blink_in = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.blink_in = 1'b0;
      bus.enable = 1'b0;
      bus.mode = 2'b00;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.leds !== 8'h00 || bus.wrap !== 1'b0) begin
         failures++;
         $display("FAIL reset_state leds=%h wrap=%b expected leds=00 wrap=0", bus.leds, bus.wrap);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h01) begin
         failures++;
         $display("FAIL reset_release leds=%h expected 01", bus.leds);
      end
   endtask

   task automatic test_rotate_left();
      logic [7:0] exp_seq [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
      bus.mode = 2'b01;
      bus.enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pulse();
         @(negedge clk);
         checks++;
         if (bus.leds !== exp_seq[i] || bus.wrap !== (i == 7)) begin
            failures++;
            $display("FAIL rotl_step%0d leds=%h wrap=%b expected leds=%h wrap=%b",
                     i, bus.leds, bus.wrap, exp_seq[i], (i == 7));
         end
         @(negedge clk);
         checks++;
         if (bus.wrap !== 1'b0) begin
            failures++;
            $display("FAIL rotl_wrap_len%0d wrap=%b expected 0", i, bus.wrap);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rotate_right();
      bus.mode = 2'b10;
      pulse();
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h80 || bus.wrap !== 1'b1) begin
         failures++;
         $display("FAIL rotr_wrap leds=%h wrap=%b expected leds=80 wrap=1", bus.leds, bus.wrap);
      end
      repeat (2) @(negedge clk);
      pulse();
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h40 || bus.wrap !== 1'b0) begin
         failures++;
         $display("FAIL rotr_step leds=%h wrap=%b expected leds=40 wrap=0", bus.leds, bus.wrap);
      end
      // Bounce must keep heading right after a rotate-right.
      bus.mode = 2'b11;
      repeat (2) @(negedge clk);
      pulse();
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h20 || bus.wrap !== 1'b0) begin
         failures++;
         $display("FAIL dir_retained leds=%h wrap=%b expected leds=20 wrap=0", bus.leds, bus.wrap);
      end
   endtask

   task automatic test_bounce();
      logic [7:0] exp_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      logic exp_wrap;
      bus.mode = 2'b00;
      do_reset();
      bus.mode = 2'b11;
      bus.enable = 1'b1;
      for (int i = 0; i < 15; i++) begin
         exp_wrap = (i == 7) || (i == 14);
         pulse();
         @(negedge clk);
         checks++;
         if (bus.leds !== exp_seq[i] || bus.wrap !== exp_wrap) begin
            failures++;
            $display("FAIL bounce_step%0d leds=%h wrap=%b expected leds=%h wrap=%b",
                     i, bus.leds, bus.wrap, exp_seq[i], exp_wrap);
         end
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_step_gating();
      @(negedge clk);
      bus.blink_in = 1'b1;
      repeat (10) @(negedge clk);
      bus.blink_in = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h04) begin
         failures++;
         $display("FAIL held_high leds=%h expected 04", bus.leds);
      end
      bus.enable = 1'b0;
      pulse();
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h04 || bus.wrap !== 1'b0) begin
         failures++;
         $display("FAIL enable_off leds=%h wrap=%b expected leds=04 wrap=0", bus.leds, bus.wrap);
      end
      bus.enable = 1'b1;
      bus.mode = 2'b00;
      pulse();
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h04 || bus.wrap !== 1'b0) begin
         failures++;
         $display("FAIL mode_hold leds=%h wrap=%b expected leds=04 wrap=0", bus.leds, bus.wrap);
      end
      bus.mode = 2'b11;
      pulse();
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h08) begin
         failures++;
         $display("FAIL gate_resume leds=%h expected 08", bus.leds);
      end
   endtask

   task automatic test_back_to_back();
      bus.mode = 2'b00;
      do_reset();
      bus.mode = 2'b01;
      bus.enable = 1'b1;
      @(negedge clk);
      bus.blink_in = 1'b1;
      @(negedge clk);
      bus.blink_in = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h02) begin
         failures++;
         $display("FAIL b2b_first leds=%h expected 02", bus.leds);
      end
      bus.blink_in = 1'b1;
      @(negedge clk);
      bus.blink_in = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h04) begin
         failures++;
         $display("FAIL b2b_second leds=%h expected 04", bus.leds);
      end
   endtask

   task automatic test_async_reset();
      pulse();
      repeat (2) @(negedge clk);
      checks++;
      if (bus.leds !== 8'h08) begin
         failures++;
         $display("FAIL pre_reset leds=%h expected 08", bus.leds);
      end
      pulse();
      repeat (2) @(negedge clk);
      checks++;
      if (bus.leds !== 8'h10) begin
         failures++;
         $display("FAIL pre_reset2 leds=%h expected 10", bus.leds);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.leds !== 8'h00 || bus.wrap !== 1'b0) begin
         failures++;
         $display("FAIL async_reset leds=%h wrap=%b expected leds=00 wrap=0", bus.leds, bus.wrap);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.leds !== 8'h01) begin
         failures++;
         $display("FAIL async_release leds=%h expected 01", bus.leds);
      end
   endtask

`ifdef LED_DIM_EN
   task automatic test_dimming();
      int on_cnt;
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.leds == 8'h01) on_cnt++;
         checks++;
         if (bus.leds !== 8'h01 && bus.leds !== 8'h00) begin
            failures++;
            $display("FAIL dim_value leds=%h expected 01 or 00", bus.leds);
         end
      end
      checks++;
      if (on_cnt != 4) begin
         failures++;
         $display("FAIL dim_duty on_cycles=%0d expected 4", on_cnt);
      end
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      bus.blink_in = 1'b0;
      bus.enable = 1'b0;
      bus.mode = 2'b00;
`ifdef LED_DIM_EN
      test_reset();
      test_dimming();
`else
      test_reset();
      test_rotate_left();
      test_rotate_right();
      test_bounce();
      test_step_gating();
      test_back_to_back();
      test_async_reset();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/led_chaser.md
# led_chaser

Downstream consumer of the `blink` stage's 1-bit LED toggle. Each rising edge of the blink signal is one step. On each step the block advances a one-hot pattern across an LED bank. Supported modes are hold, rotate-left, rotate-right and bounce. The registered pattern drives the board LEDs directly, with optional PWM dimming.

## Interface
- `WIDTH`, 8: number of LEDs; must be ≥ 2.
- `DUTY_BITS`, 4: width of the PWM counter. Used only with `LED_DIM_EN`.
- `DUTY`, 8: on-count per PWM period of 2^`DUTY_BITS` clk cycles. Used only with `LED_DIM_EN`.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `blink_in`  input  1  blink-stage output, same `clk` domain; a rising edge is one step.
- `enable`  input  1  when 0, steps are ignored.
- `mode`  input  2  00 hold, 01 rotate left, 10 rotate right, 11 bounce.
- `leds`  output  WIDTH  registered LED drive.
- `wrap`  output  1  one-cycle pulse, aligned with `leds`, when the lit bit leaves an end position.

## Operation
- Registers:
  - `blink_d`: previous `blink_in`.
  - `pattern`: one-hot, WIDTH bits.
  - `dir`: 0 = left, 1 = right.
  - `leds`, `wrap`.
  - `pwm_cnt`: present only with `LED_DIM_EN`.
- Reset values: `blink_d`=0, `pattern`=1 (LSB lit), `dir`=left, `leds`=0, `wrap`=0, `pwm_cnt`=0.
- Step detection: `step` = `blink_in` & ~`blink_d`. `blink_d` tracks `blink_in` every cycle, regardless of `enable` or `mode`.
- A step is taken only if `step` & `enable` & (`mode` ≠ 00).
- Mode 01, rotate left:
  - `pattern` ← {`pattern`[WIDTH-2:0], `pattern`[WIDTH-1]}; `dir` ← left.
  - Wrap when `pattern`[WIDTH-1] was set before the step.
- Mode 10, rotate right:
  - `pattern` ← {`pattern`[0], `pattern`[WIDTH-1:1]}; `dir` ← right.
  - Wrap when `pattern`[0] was set before the step.
- Mode 11, bounce (two-state direction FSM, LEFT/RIGHT):
  - LEFT with `pattern`[WIDTH-1] set: go to RIGHT, shift right, wrap.
  - RIGHT with `pattern`[0] set: go to LEFT, shift left, wrap.
  - Otherwise: shift one position in the current direction; no wrap.
- Mode changes take effect on the next step. `pattern` and `dir` are retained across mode changes, so a rotate followed by bounce continues in the same direction.
- `pattern` stays one-hot at all times; there is never an all-zero or multi-hot pattern.
- `leds` ← `pattern` (masked per Configuration); `wrap` ← the wrap condition of the step. Both are registered together.

## Timing
- A `blink_in` rise sampled at edge k updates `pattern` at edge k.
- `leds` and `wrap` reflect that update at edge k+1, i.e. 1-cycle latency from detection.
- `wrap` is high for exactly one cycle per wrapping step.
- A `blink_in` held high for many cycles produces one step. Back-to-back steps need `blink_in` low for at least one sampled cycle between rises.
- Reset is asynchronous: all registers clear immediately on `rst` high, mid-step included. The first step after release must see `blink_in` rise from a sampled 0.
- A step arriving in the same cycle as an `enable` or `mode` change uses the values sampled at that edge.

## Configuration
- `LED_DIM_EN` defined:
  - `pwm_cnt` (DUTY_BITS wide) increments every cycle and wraps to 0.
  - `leds` ← `pattern` when `pwm_cnt` < `DUTY`, else 0.
  - `DUTY`=0 keeps `leds` permanently 0; `DUTY` ≥ 2^`DUTY_BITS` keeps `leds` permanently on.
  - `wrap` is unaffected by the PWM mask.
- `LED_DIM_EN` undefined: no PWM counter; `leds` ← `pattern` every cycle; `DUTY` and `DUTY_BITS` are ignored.

## Test plan
- Reset: assert `rst` with `leds` previously 8'h10 → `leds`=8'h00 and `wrap`=0 immediately. One cycle after release, `leds`=8'h01.
- Rotate left: `mode`=01, `enable`=1, 8 single-cycle `blink_in` pulses spaced 4 cycles apart → `leds` steps 02, 04, …, 80, 01. `wrap`=1 only with 01.
- Rotate right after left: from `leds`=8'h01, set `mode`=10, one pulse → `leds`=8'h80 with `wrap`=1.
- Bounce: after reset, `mode`=11, 15 pulses → `leds` 02…80, then 40…01, then 02. `wrap` pulses at 80→40 and at 01→02 only.
- Step gating: hold `blink_in` high for 10 cycles → exactly one step. With `enable`=0 or `mode`=00, pulses leave `leds` unchanged and `wrap`=0.
- Dimming (`LED_DIM_EN`, `DUTY_BITS`=4, `DUTY`=4): `leds` equals the pattern for 4 of every 16 cycles and is 0 otherwise. A `rst` pulse mid-period zeroes `leds` at once.
